// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: memory access widths,
// the NOP filler, default memory window and the FIFO entry layout.
package fetch_pkg;

  localparam logic [1:0]  WIDTH_BYTE = 2'b00;
  localparam logic [1:0]  WIDTH_HALF = 2'b01;
  localparam logic [1:0]  WIDTH_WORD = 2'b10;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] START_PC_DEF = 32'h0100_0000;
  localparam int unsigned MEM_SIZE_DEF = 1048576;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  // 33-bit window arithmetic so base+size never wraps
  function automatic logic pc_fault(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input logic [32:0] size);
    logic [32:0] last;
    last = {1'b0, base} + size - 33'd4;
    return (pc[1:0] != 2'b00) | (pc < base) | ({1'b0, pc} > last);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, inst, fault} entries; no bypass, so an
// entry becomes visible the cycle after it is pushed.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage is not reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads one word per cycle from
// instruction memory, tags faults and queues entries for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_PC = START_PC_DEF,
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data_in,
  output logic        imem_w_enable,
  output logic [1:0]  imem_width,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]  r_fetch_pc;
  logic         w_fault;
  logic         w_pop;
  logic         w_push;
  logic         w_full;
  logic         w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_rd_entry;

  assign imem_address  = r_fetch_pc;
  assign imem_data_in  = 32'h0;
  assign imem_w_enable = 1'b0;
  assign imem_width    = WIDTH_WORD;

  assign w_fault = pc_fault(r_fetch_pc, START_PC, 33'(MEM_SIZE));

  // Faulting fetches carry NOP so undefined memory data never reaches decode.
  assign w_wr_entry.pc    = r_fetch_pc;
  assign w_wr_entry.inst  = w_fault ? NOP_INST : imem_data_out;
  assign w_wr_entry.fault = w_fault;

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = ~redirect_valid & (~w_full | w_pop);

  // Fetch PC stage
  always_ff @(posedge clk) begin
    if (reset)               r_fetch_pc <= START_PC;
    else if (redirect_valid) r_fetch_pc <= redirect_pc;
    else if (w_push)         r_fetch_pc <= r_fetch_pc + 32'd4;
  end

  // Queue stage
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wr_entry),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_pc    = w_empty ? 32'h0 : w_rd_entry.pc;
  assign out_inst  = w_empty ? 32'h0 : w_rd_entry.inst;
  assign out_fault = ~w_empty & w_rd_entry.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

  localparam logic [31:0] SPC  = 32'h0100_0000;
  localparam logic [31:0] LAST = 32'h010F_FFFC;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          QCAP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_address;
  logic [31:0] imem_data_in;
  logic        imem_w_enable;
  logic [1:0]  imem_width;
  logic [31:0] imem_data_out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  always #5 clk = ~clk;

  fetch_unit #(.START_PC(SPC), .MEM_SIZE(1048576), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_address(imem_address), .imem_data_in(imem_data_in),
    .imem_w_enable(imem_w_enable), .imem_width(imem_width),
    .imem_data_out(imem_data_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_fault(out_fault)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0100_0000: return 32'h0050_0093;
      32'h0100_0004: return 32'h00A0_0113;
      32'h0100_0008: return 32'h0020_81B3;
      default:       return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endcase
  endfunction

  assign imem_data_out = mem_rd(imem_address);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = SPC;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic ref_fault(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < SPC) || (pc > LAST);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("imem_address", imem_address, m_pc);
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("imem_w_enable", 32'(imem_w_enable), 32'h0);
    chk("imem_width", 32'(imem_width), 32'h2);
    chk("imem_data_in", imem_data_in, 32'h0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_fault", 32'(out_fault), 32'(mq[0].fault));
    end else begin
      chk("out_pc_empty", out_pc, 32'h0);
      chk("out_inst_empty", out_inst, 32'h0);
      chk("out_fault_empty", 32'(out_fault), 32'h0);
    end
  endtask

  // One clock: apply inputs, advance the model, then check after the edge.
  task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    ent_t e;
    logic pop;
    reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    pop = (mq.size() != 0) && rdy;
    if (rst) begin
      mq.delete(); m_pc = SPC;
    end else if (rv) begin
      mq.delete(); m_pc = rpc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mq.size() < QCAP) begin
        e.pc = m_pc;
        e.fault = ref_fault(m_pc);
        e.inst = e.fault ? NOP : mem_rd(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] rpc;
    cyc(1, 0, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_addr", imem_address, 32'h0100_0000);

    // sustained fetch
    cyc(0, 0, 0, 1);
    chk("t1_pc0", out_pc, 32'h0100_0000); chk("t1_inst0", out_inst, 32'h0050_0093);
    cyc(0, 0, 0, 1);
    chk("t1_pc1", out_pc, 32'h0100_0004); chk("t1_inst1", out_inst, 32'h00A0_0113);
    cyc(0, 0, 0, 1);
    chk("t1_pc2", out_pc, 32'h0100_0008); chk("t1_inst2", out_inst, 32'h0020_81B3);
    chk("t1_fault", 32'(out_fault), 32'h0);

    // backpressure
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("t2_addr_hold", imem_address, 32'h0100_0008);
    chk("t2_head_hold", out_pc, 32'h0100_0000);
    cyc(0, 0, 0, 1);
    chk("t2_pc1", out_pc, 32'h0100_0004);
    cyc(0, 0, 0, 1);
    chk("t2_pc2", out_pc, 32'h0100_0008);

    // redirect while full
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h0100_0100, 0);
    chk("t3_valid", 32'(out_valid), 32'h0);
    chk("t3_addr", imem_address, 32'h0100_0100);
    cyc(0, 0, 0, 0);
    chk("t3_pc", out_pc, 32'h0100_0100);

    // redirect with pop while full
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h0100_0200, 1);
    chk("t4_valid", 32'(out_valid), 32'h0);
    cyc(0, 0, 0, 1);
    chk("t4_pc", out_pc, 32'h0100_0200);

    // faults
    cyc(0, 1, 32'h0100_0102, 0);
    cyc(0, 0, 0, 0);
    chk("t5_mis_pc", out_pc, 32'h0100_0102);
    chk("t5_mis_fault", 32'(out_fault), 32'h1);
    chk("t5_mis_inst", out_inst, 32'h0000_0013);
    cyc(0, 0, 0, 1);
    chk("t5_mis2_pc", out_pc, 32'h0100_0106);
    chk("t5_mis2_fault", 32'(out_fault), 32'h1);
    cyc(0, 1, 32'h0, 0);
    cyc(0, 0, 0, 0);
    chk("t5_low_fault", 32'(out_fault), 32'h1);
    chk("t5_low_inst", out_inst, 32'h0000_0013);
    cyc(0, 1, 32'h010F_FFFC, 0);
    cyc(0, 0, 0, 1);
    chk("t5_top_fault", 32'(out_fault), 32'h0);
    cyc(0, 0, 0, 1);
    chk("t5_over_pc", out_pc, 32'h0110_0000);
    chk("t5_over_fault", 32'(out_fault), 32'h1);

    // reset beats redirect mid-stream
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h0100_0300, 1);
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_addr", imem_address, 32'h0100_0000);
    cyc(0, 0, 0, 1);
    chk("t6_pc", out_pc, 32'h0100_0000);
    chk("t6_inst", out_inst, 32'h0050_0093);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rpc = SPC + ($urandom_range(0, 255) << 2);
        6:       rpc = SPC + $urandom_range(0, 1023);
        7:       rpc = LAST - ($urandom_range(0, 3) << 2);
        8:       rpc = $urandom;
        default: rpc = 32'hFFFF_FFF8;
      endcase
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0), rpc,
          ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of decode and driving the instruction-side port of the byte-addressable main memory (combinational read, word width).
- Holds the fetch PC and reads one word per cycle from memory.
- Buffers fetched words with their PC in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush, and tags misaligned or out-of-range fetches as faults.

Parameters:
START_PC, 32'h01000000, fetch PC after reset; base of memory
MEM_SIZE, 1048576, memory size in bytes; legal fetch range is [START_PC, START_PC+MEM_SIZE-4]
DEPTH, 2, FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
imem_address  output  32  memory read address (= fetch_pc, combinational)
imem_data_in  output  32  memory write data, tied 0
imem_w_enable  output  1  tied 0
imem_width  output  2  tied WIDTH_WORD (2'b10)
imem_data_out  input  32  memory read data, valid same cycle as imem_address
redirect_valid  input  1  load redirect_pc, flush FIFO
redirect_pc  input  32  new fetch target
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head
out_inst  output  32  head instruction word
out_pc  output  32  head PC
out_fault  output  1  head fetch was misaligned or out of range

Behaviour:
- Reset (reset=1 at clk edge): fetch_pc<=START_PC, FIFO count<=0, rd/wr pointers<=0. Outputs in the following cycle: out_valid=0, imem_address=START_PC. out_inst, out_pc and out_fault read 0 while empty.
- out_valid = (count!=0), from registered state only. It has no combinational path from redirect_valid or out_ready.
- pop = out_valid & out_ready.
- push = ~redirect_valid & (count<DEPTH | pop). Push and pop in the same cycle are allowed, including when full; count is then unchanged.
- On push: the entry stores {fetch_pc, data, fault}, and fetch_pc<=fetch_pc+4 (mod 2^32, wraps).
- If not pushing and not redirecting, fetch_pc holds.
- fault = (fetch_pc[1:0]!=0) | fetch_pc<START_PC | fetch_pc>START_PC+MEM_SIZE-4.
- When fault=1, the stored data is NOP (32'h00000013) rather than imem_data_out, so X from memory never propagates.
- Latency: a word pushed at edge N is at the FIFO head (out_valid=1) in the cycle after edge N. Sustained throughput with out_ready=1 is 1 instruction/cycle.
- Redirect, which has highest priority after reset:
  - At the edge: FIFO flushed (count<=0, pointers<=0), fetch_pc<=redirect_pc, no push.
  - A pop handshake in the redirect cycle still completes; decode owns that entry.
  - Next cycle: out_valid=0 and imem_address=redirect_pc. The first redirected word appears at the head one cycle later.
  - A misaligned redirect_pc is kept unmodified. It produces a fault entry and fetch continues at +4 from it.
- Back-to-back redirects: each one restarts from its own redirect_pc; the last one wins.
- Reset mid-operation overrides redirect, push and pop. All FIFO contents are discarded.
- No X on any output after the first reset, including while empty.

Decomposition:
- Shared package fetch_pkg: WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10, NOP_INST=32'h00000013, START_PC/MEM_SIZE defaults. The same width encoding is used by the data-side load/store unit.
- One sub-module: fetch_fifo. It is a synchronous FIFO with parameter DEPTH and WIDTH=65 ({pc, inst, fault}), with push, pop, flush and full/empty/count. It has no bypass: an entry is visible the cycle after push.
- fetch_unit contains the PC register, fault check, push/pop/redirect control and memory port tie-offs.

Test Plan:
1. Sustained fetch.
   - Stimulus: reset, then out_ready=1; memory at 0x01000000/04/08 = 0x00500093/0x00A00113/0x002081B3.
   - Required: out_valid rises one cycle after reset drops; out_pc sequence 0x01000000, 0x01000004, 0x01000008 on consecutive cycles with matching out_inst; out_fault=0.
2. Backpressure.
   - Stimulus: out_ready=0 for 5 cycles after first valid.
   - Required: count saturates at 2; imem_address holds 0x01000008; out_pc stays 0x01000000.
   - Stimulus: release out_ready.
   - Required: 0x..00, 0x..04, 0x..08 delivered in order with no drop or duplicate.
3. Redirect while full.
   - Stimulus: FIFO full, redirect_valid=1 with redirect_pc=0x01000100, out_ready=0.
   - Required: next cycle out_valid=0, imem_address=0x01000100; following cycle out_pc=0x01000100. No old entries reappear.
4. Simultaneous redirect, pop and full.
   - Stimulus: FIFO full, out_ready=1, redirect to 0x01000200 in the same cycle.
   - Required: head consumed once; no push; count=0 next cycle; next delivered out_pc=0x01000200.
5. Faults.
   - Stimulus: redirect to 0x01000102.
   - Required: entry out_pc=0x01000102, out_fault=1, out_inst=0x00000013; the next entry (0x01000106) is also faulted.
   - Stimulus: redirect to 0x00000000.
   - Required: out_fault=1, out_inst=NOP.
   - Stimulus: redirect to 0x010FFFFC.
   - Required: out_fault=0; the next entry (0x01100000) has out_fault=1.
6. Reset mid-stream.
   - Stimulus: FIFO full, redirect_valid=1 and reset=1 in the same cycle.
   - Required: next cycle out_valid=0 and imem_address=0x01000000 (reset beats redirect); normal fetch resumes from START_PC.
